d_ff: RTL and testbench

D_FF -- requirements
Module: d_ff

---
 rtl/d_ff_pkg.sv | 14 +
 rtl/d_ff_bit.sv | 29 ++
 rtl/d_ff.sv | 54 +++++
 tb/tb_d_ff.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/d_ff_pkg.sv
// Shared defaults and legal bounds for the d_ff register slice.
package d_ff_pkg;

    localparam int WIDTH_DEFAULT = 1;
    localparam int WIDTH_MIN     = 1;
    localparam int WIDTH_MAX     = 64;

    localparam logic [WIDTH_MAX-1:0] RST_VAL_DEFAULT = '0;

    function automatic bit width_ok(input int w);
        return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
    endfunction

endpackage

// File: rtl/d_ff_bit.sv
// Single-bit flop with synchronous active-high reset to a per-bit value.
module d_ff_bit #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic qb
);

    logic q_d;
    logic q_q;

    always_comb begin
        q_d = d;
        if (rst) begin
            q_d = RST_VAL;
        end
    end

    always_ff @(posedge clk) begin
        q_q <= q_d;
    end

    assign q  = q_q;
    assign qb = ~q_q;

endmodule

// File: rtl/d_ff.sv
// WIDTH-bit register built from independent per-bit flops; qb is the complement of q.
module d_ff
    import d_ff_pkg::*;
#(
    parameter int                 WIDTH   = WIDTH_DEFAULT,
    parameter logic [WIDTH-1:0]   RST_VAL = RST_VAL_DEFAULT[WIDTH-1:0]
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb
);

    if (!width_ok(WIDTH)) begin : g_width_check
        $error("d_ff: WIDTH=%0d outside legal range %0d..%0d", WIDTH, WIDTH_MIN, WIDTH_MAX);
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        d_ff_bit #(
            .RST_VAL (RST_VAL[i])
        ) u_bit (
            .clk (clk),
            .rst (rst),
            .d   (d[i]),
            .q   (q[i]),
            .qb  (qb[i])
        );
    end

`ifndef SYNTHESIS
    // warm_q marks that a reset edge has been seen, so $past history is meaningful.
    logic warm_d;
    logic warm_q;

    always_comb begin
        warm_d = warm_q | rst;
    end

    always_ff @(posedge clk) begin
        warm_q <= warm_d;
    end

    a_qb_inv: assert property (@(posedge clk) warm_q |-> (qb == ~q))
        else $error("d_ff: qb is not the complement of q");

    a_capture: assert property (@(posedge clk) (warm_q && !$past(rst)) |-> (q == $past(d)))
        else $error("d_ff: q did not capture previous d");

    a_reset: assert property (@(posedge clk) (warm_q && $past(rst)) |-> (q == RST_VAL))
        else $error("d_ff: q not at reset value after reset edge");
`endif

endmodule

// File: tb/tb_d_ff.sv
// Directed scoreboard bench for d_ff: a 1-bit default instance and an 8-bit instance resetting to A5.
module tb_d_ff;

    logic       clk = 1'b0;
    logic       rst1;
    logic       d1;
    logic       q1;
    logic       qb1;
    logic       rst8;
    logic [7:0] d8;
    logic [7:0] q8;
    logic [7:0] qb8;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit         wide;
        logic [7:0] q;
        logic [7:0] qb;
        string      name;
    } exp_t;

    exp_t sb[$];
    event mon_ev;

    always #2 clk = ~clk;

    d_ff u_dut1 (
        .clk (clk),
        .rst (rst1),
        .d   (d1),
        .q   (q1),
        .qb  (qb1)
    );

    d_ff #(
        .WIDTH   (8),
        .RST_VAL (8'hA5)
    ) u_dut8 (
        .clk (clk),
        .rst (rst8),
        .d   (d8),
        .q   (q8),
        .qb  (qb8)
    );

    function automatic void push(input bit wide, input logic [7:0] eq, input string nm);
        exp_t e;
        e.wide = wide;
        e.q    = wide ? eq : {7'b0, eq[0]};
        e.qb   = wide ? ~eq : {7'b0, ~eq[0]};
        e.name = wide ? {nm, "_w8"} : {nm, "_w1"};
        sb.push_back(e);
    endfunction

    // Monitor: drains the scoreboard on each falling edge or on a mid-cycle request.
    initial begin
        exp_t       e;
        logic [7:0] aq;
        logic [7:0] aqb;
        forever begin
            @(negedge clk or mon_ev);
            while (sb.size() != 0) begin
                e   = sb.pop_front();
                aq  = e.wide ? q8  : {7'b0, q1};
                aqb = e.wide ? qb8 : {7'b0, qb1};
                checks++;
                if (aq !== e.q || aqb !== e.qb) begin
                    errors++;
                    $display("FAIL %s: got q=%h qb=%h, expected q=%h qb=%h",
                             e.name, aq, aqb, e.q, e.qb);
                end
            end
        end
    end

    // Applies inputs at the falling edge, expects the result of the next rising edge.
    task automatic step(input logic r1, input logic v1, input logic r8, input logic [7:0] v8,
                        input logic e1, input logic [7:0] e8, input string nm);
        rst1 = r1;
        d1   = v1;
        rst8 = r8;
        d8   = v8;
        @(posedge clk);
        push(1'b0, {7'b0, e1}, nm);
        push(1'b1, e8, nm);
        @(negedge clk);
    endtask

    task automatic mid_check(input logic e1, input logic [7:0] e8, input string nm);
        push(1'b0, {7'b0, e1}, nm);
        push(1'b1, e8, nm);
        ->mon_ev;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not end, got timeout, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst1 = 1'b1;
        d1   = 1'b1;
        rst8 = 1'b1;
        d8   = 8'h00;
        @(negedge clk);

        // Reset held for two edges while d is active
        step(1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 8'hA5, "reset_e1");
        step(1'b1, 1'b1, 1'b1, 8'h3C, 1'b0, 8'hA5, "reset_e2");

        // Capture: new d visible only after the next rising edge
        rst1 = 1'b0; d1 = 1'b1; rst8 = 1'b0; d8 = 8'h3C;
        #1 mid_check(1'b0, 8'hA5, "capture_before");
        @(negedge clk);
        step(1'b0, 1'b1, 1'b0, 8'h3C, 1'b1, 8'h3C, "capture");

        // Toggle every edge
        for (int i = 0; i < 6; i++) begin
            logic       tv;
            logic [7:0] wv;
            tv = (i % 2 == 0) ? 1'b0 : 1'b1;
            wv = (i % 2 == 0) ? 8'hF0 : 8'h0F;
            step(1'b0, tv, 1'b0, wv, tv, wv, $sformatf("toggle%0d", i));
        end

        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, "pre_glitch");

        // Glitch entirely between edges
        d1 = 1'b1; d8 = 8'hFF;
        #1;
        d1 = 1'b0; d8 = 8'h00;
        mid_check(1'b0, 8'h00, "glitch_mid");
        @(negedge clk);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, "glitch_after");

        // Reset raised mid-cycle with d=1
        step(1'b0, 1'b1, 1'b0, 8'hC3, 1'b1, 8'hC3, "pre_rst");
        #1;
        rst1 = 1'b1; rst8 = 1'b1;
        mid_check(1'b1, 8'hC3, "rst_mid_hold");
        @(negedge clk);
        step(1'b1, 1'b1, 1'b1, 8'hC3, 1'b0, 8'hA5, "rst_mid_edge");
        step(1'b1, 1'b1, 1'b1, 8'h77, 1'b0, 8'hA5, "rst_held");
        #1;
        rst1 = 1'b0; rst8 = 1'b0; d1 = 1'b1; d8 = 8'h5A;
        mid_check(1'b0, 8'hA5, "rst_release_mid");
        @(negedge clk);
        step(1'b0, 1'b1, 1'b0, 8'h5A, 1'b1, 8'h5A, "rst_release");

        // Wide variant: fresh reset then 3C
        step(1'b1, 1'b0, 1'b1, 8'hFF, 1'b0, 8'hA5, "wide_reset");
        step(1'b0, 1'b1, 1'b0, 8'h3C, 1'b1, 8'h3C, "wide_3c");

        repeat (30) @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending entries, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
